// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers a payload, then sends header, payload and parity bytes.
// Latency: header on tx_data one cycle after the last payload write; one byte per cycle when not stalled.
// Backpressure: busy=1 holds pkt_valid/tx_data; pl_ready=1 only while loading the payload buffer.
module router_pkt_tx #(
  parameter int CHECK_CYCLES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] addr,
  input  logic [5:0] len,
  input  logic       corrupt_parity,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [7:0] tx_data,
  output logic       idle,
  output logic       done,
  output logic       pkt_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_CHECK
  } state_t;

  localparam logic [3:0] CHK_LAST = 4'(CHECK_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] addr_q, addr_nxt;
  logic [5:0] len_q, len_nxt;
  logic       corrupt_q, corrupt_nxt;
  logic [5:0] wr_cnt, wr_nxt;
  logic [5:0] rd_cnt, rd_nxt;
  logic [7:0] parity, parity_nxt;
  logic [3:0] chk_cnt, chk_nxt;
  logic       mem_we;

  logic       pl_ready_nxt, pkt_valid_nxt, idle_nxt, done_nxt, pkt_err_nxt;
  logic [7:0] tx_data_nxt;

  logic [7:0] mem [64];
  logic [5:0] len_last;
  logic [5:0] rd_inc;

  assign len_last = len_q - 6'd1;
  assign rd_inc   = rd_cnt + 6'd1;

  // Payload buffer write port; contents need no reset since counters gate every read.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_cnt] <= pl_data;
    end
  end

  // State, counters, parity and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      corrupt_q <= 1'b0;
      wr_cnt    <= 6'd0;
      rd_cnt    <= 6'd0;
      parity    <= 8'd0;
      chk_cnt   <= 4'd0;
      pl_ready  <= 1'b0;
      pkt_valid <= 1'b0;
      tx_data   <= 8'd0;
      idle      <= 1'b1;
      done      <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      len_q     <= len_nxt;
      corrupt_q <= corrupt_nxt;
      wr_cnt    <= wr_nxt;
      rd_cnt    <= rd_nxt;
      parity    <= parity_nxt;
      chk_cnt   <= chk_nxt;
      pl_ready  <= pl_ready_nxt;
      pkt_valid <= pkt_valid_nxt;
      tx_data   <= tx_data_nxt;
      idle      <= idle_nxt;
      done      <= done_nxt;
      pkt_err   <= pkt_err_nxt;
    end
  end

  // Next state plus next output values, so every output comes straight from a flop.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_q;
    len_nxt       = len_q;
    corrupt_nxt   = corrupt_q;
    wr_nxt        = wr_cnt;
    rd_nxt        = rd_cnt;
    parity_nxt    = parity;
    chk_nxt       = chk_cnt;
    mem_we        = 1'b0;
    pl_ready_nxt  = pl_ready;
    pkt_valid_nxt = pkt_valid;
    tx_data_nxt   = tx_data;
    idle_nxt      = idle;
    done_nxt      = 1'b0;
    pkt_err_nxt   = pkt_err;

    case (state)
      S_IDLE: begin
        // A zero-length request is dropped without leaving IDLE.
        if (start && (len != 6'd0)) begin
          addr_nxt     = addr;
          len_nxt      = len;
          corrupt_nxt  = corrupt_parity;
          parity_nxt   = {len, addr};
          wr_nxt       = 6'd0;
          rd_nxt       = 6'd0;
          state_nxt    = S_LOAD;
          pl_ready_nxt = 1'b1;
          idle_nxt     = 1'b0;
        end
      end
      S_LOAD: begin
        if (pl_valid) begin
          mem_we     = 1'b1;
          parity_nxt = parity ^ pl_data;
          wr_nxt     = wr_cnt + 6'd1;
          if (wr_cnt == len_last) begin
            state_nxt     = S_HEADER;
            pl_ready_nxt  = 1'b0;
            pkt_valid_nxt = 1'b1;
            tx_data_nxt   = {len_q, addr_q};
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          state_nxt   = S_PAYLOAD;
          tx_data_nxt = mem[rd_cnt];
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          rd_nxt = rd_inc;
          if (rd_cnt == len_last) begin
            // Parity goes out with pkt_valid low, which is how the router recognises it.
            state_nxt     = S_PARITY;
            pkt_valid_nxt = 1'b0;
            tx_data_nxt   = parity ^ {8{corrupt_q}};
          end else begin
            tx_data_nxt = mem[rd_inc];
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          state_nxt   = S_CHECK;
          tx_data_nxt = 8'd0;
          chk_nxt     = 4'd0;
        end
      end
      S_CHECK: begin
        // Give the router time to settle err before sampling it.
        if (chk_cnt == CHK_LAST) begin
          state_nxt   = S_IDLE;
          idle_nxt    = 1'b1;
          done_nxt    = 1'b1;
          pkt_err_nxt = err;
        end else begin
          chk_nxt = chk_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the 1x3 router input port. It accepts a destination address, a payload length and the payload bytes from a host-side stream, and buffers the whole payload. It then drives the router's `pkt_valid`/`data_in` input as a header byte, the payload bytes and a parity byte, stalling whenever the router asserts `busy`. After the parity byte, it samples the router's `err` flag and reports the result per packet.

## Interface
- `CHECK_CYCLES`, default 3: cycles to wait after the parity byte is accepted before sampling `err`; legal range 1–15.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to send a packet; accepted only when `idle`=1.
- `addr`  in  2  destination port 0–2; sampled with `start`. Value 3 is not filtered.
- `len`  in  6  payload length 1–63; sampled with `start`.
- `corrupt_parity`  in  1  sampled with `start`; when 1, the parity byte sent is inverted.
- `pl_data`  in  8  payload byte from host.
- `pl_valid`  in  1  `pl_data` valid.
- `pl_ready`  out  1  block accepts a payload byte this cycle.
- `busy`  in  1  router stall; while 1, `pkt_valid`/`tx_data` are held.
- `err`  in  1  router parity-error flag.
- `pkt_valid`  out  1  to router `pkt_valid`.
- `tx_data`  out  8  to router `data_in`.
- `idle`  out  1  ready for `start`.
- `done`  out  1  one-cycle pulse at end of packet.
- `pkt_err`  out  1  `err` value sampled for the last packet; held until the next `done`.

## Operation
- Frame format:
  - header = {len[5:0], addr[1:0]};
  - then `len` payload bytes;
  - then parity = XOR of the header and all payload bytes, inverted if `corrupt_parity` was set.
  - `pkt_valid`=1 for header and payload bytes; `pkt_valid`=0 while the parity byte is on `tx_data`.
- Storage: 64x8 payload buffer, 6-bit write and read counters, 8-bit running parity register.
- State machine, states IDLE, LOAD, HEADER, PAYLOAD, PARITY, CHECK:
  - IDLE: `idle`=1. `start` with `len`≠0 latches `addr`, `len` and `corrupt_parity`, seeds parity with the header byte, and moves to LOAD. `start` with `len`=0 is ignored; the block stays in IDLE.
  - LOAD: `pl_ready`=1. Each cycle with `pl_valid`=1 writes the buffer and XORs the byte into parity. After byte number `len` is written, moves to HEADER. Gaps in `pl_valid` simply wait.
  - HEADER: drives the header byte. The byte is accepted in any cycle where `busy`=0; the block then moves to PAYLOAD.
  - PAYLOAD: drives buffer[rd]. On acceptance, rd increments. After byte number `len` is accepted, moves to PARITY.
  - PARITY: drives the parity byte with `pkt_valid`=0. On acceptance, moves to CHECK.
  - CHECK: counts `CHECK_CYCLES` cycles. In the last cycle it samples `err` into `pkt_err`, pulses `done`, and returns to IDLE.
- `start` is ignored in every state except IDLE.
- `busy` is ignored in IDLE, LOAD and CHECK.

## Timing
- Reset values: `pkt_valid`=0, `tx_data`=0x00, `pl_ready`=0, `idle`=1, `done`=0, `pkt_err`=0; state IDLE; counters and parity cleared.
- Reset asserted mid-packet aborts the packet. The reset values above hold on the next edge, and no `done` is issued for the aborted packet.
- All outputs are registered.
- `start` at edge T puts the block in LOAD at T+1 with `pl_ready`=1.
- The last payload write at edge W puts the header on `tx_data` with `pkt_valid`=1 from W+1.
- Handshake:
  - A byte is accepted at an edge where the block is in HEADER, PAYLOAD or PARITY and `busy`=0.
  - The next byte is driven in the following cycle, giving one byte per cycle with no bubbles when `busy` stays 0.
  - While `busy`=1, `tx_data` and `pkt_valid` must not change.
- Minimum packet time with `busy`=0 and no `pl_valid` gaps: 1 (start) + `len` (load) + 1 (header) + `len` (payload) + 1 (parity) + `CHECK_CYCLES` cycles.
- After parity acceptance, `pkt_valid` stays 0 and `tx_data` returns to 0x00.
- `done` is high for exactly one cycle.
- `idle` rises in the same cycle that `done` is asserted, so a `start` in that cycle is accepted.

## Test plan
- `addr`=1, `len`=3, payload 0x11, 0x22, 0x33, `busy`=0 → `tx_data` sequence 0x0D, 0x11, 0x22, 0x33 with `pkt_valid`=1, then 0x0D with `pkt_valid`=0. `done` pulses after 3 CHECK cycles; router model `err`=0 gives `pkt_err`=0.
- Same packet, with `busy`=1 for 2 cycles while the header is on the bus and again for 1 cycle mid-payload → each byte is held stable and appears exactly once; the final byte stream is identical to the previous case.
- `corrupt_parity`=1 on the same packet → parity byte 0xF2. Router model raises `err` → `pkt_err`=1; the next clean packet returns `pkt_err` to 0.
- `start` with `len`=0 → `idle` stays 1, `pl_ready` stays 0, `pkt_valid` stays 0, no `done`.
- `len`=63 with random `pl_valid` gaps → `pl_ready` drops after 63 writes; 65 bytes are sent; parity is correct; the buffer wraps cleanly.
- `reset` pulsed while in PAYLOAD → next cycle `pkt_valid`=0, `tx_data`=0x00, `idle`=1, no `done`; a following packet is sent correctly.
